// File: rtl/raw_tracker.sv
// raw_tracker: per-thread, per-register-file producer table used to detect RAW hazards at issue.
// Lookups read registered state directly; issue, clear and flush update it on the next edge.
module raw_tracker #(
    parameter int NR_SB_ENTRIES   = 8,
    parameter int TRANS_ID_BITS   = $clog2(NR_SB_ENTRIES),
    parameter int NUM_THREADS     = 2,
    parameter int NUM_THREADS_LOG = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    parameter int NR_RS           = 3,
    parameter int NR_CLR          = 2,
    parameter int FP_PRESENT      = 1,
    parameter int CNT_BITS        = $clog2(NUM_THREADS*64+1)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [NUM_THREADS-1:0]                      flush_i,
    input  logic                                        issue_valid_i,
    input  logic                                        issue_we_i,
    input  logic [NUM_THREADS_LOG-1:0]                  issue_thread_i,
    input  logic [4:0]                                  issue_rd_i,
    input  logic                                        issue_rd_fpr_i,
    input  logic [TRANS_ID_BITS-1:0]                    issue_trans_id_i,
    input  logic [NR_CLR-1:0]                           clr_valid_i,
    input  logic [NR_CLR-1:0][TRANS_ID_BITS-1:0]        clr_trans_id_i,
    input  logic [NR_RS-1:0][4:0]                       rs_i,
    input  logic [NR_RS-1:0]                            rs_fpr_i,
    input  logic [NR_RS-1:0][NUM_THREADS_LOG-1:0]       rs_thread_i,
    output logic [NR_RS-1:0]                            valid_o,
    output logic [NR_RS-1:0][TRANS_ID_BITS-1:0]         idx_o,
    output logic [NUM_THREADS-1:0][CNT_BITS-1:0]        pending_cnt_o,
    output logic [NUM_THREADS-1:0]                      empty_o
);

    localparam int NREG = 32;

    logic                     slot_v   [NUM_THREADS][2][NREG];
    logic [TRANS_ID_BITS-1:0] slot_id  [NUM_THREADS][2][NREG];
    logic                     slot_wr  [NUM_THREADS][2][NREG];
    logic                     slot_clr [NUM_THREADS][2][NREG];
    logic [NUM_THREADS-1:0]   cnt_inc;
    logic [6:0]               clr_cnt  [NUM_THREADS];
    logic signed [CNT_BITS+1:0] cnt_calc [NUM_THREADS];
    logic [CNT_BITS-1:0]      cnt_q    [NUM_THREADS];
    logic                     issue_ok;

    function automatic logic clr_match(input logic [TRANS_ID_BITS-1:0] id);
        logic m;
        m = 1'b0;
        for (int k = 0; k < NR_CLR; k++) begin
            if (clr_valid_i[k] && clr_trans_id_i[k] == id) m = 1'b1;
        end
        return m;
    endfunction

    function automatic logic slot_exists(input logic fpr, input logic [4:0] rd);
        return !((!fpr && rd == 5'd0) || (fpr && FP_PRESENT == 0));
    endfunction

    always_comb begin
        issue_ok = issue_valid_i && issue_we_i && slot_exists(issue_rd_fpr_i, issue_rd_i);
        if (int'(issue_thread_i) >= NUM_THREADS) issue_ok = 1'b0;
        else if (flush_i[issue_thread_i]) issue_ok = 1'b0;
    end

    // An issue into a slot masks any clear of that slot's previous producer in the same cycle.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            cnt_inc[t] = 1'b0;
            clr_cnt[t] = '0;
            for (int f = 0; f < 2; f++) begin
                for (int r = 0; r < NREG; r++) begin
                    slot_wr[t][f][r]  = issue_ok && (int'(issue_thread_i) == t)
                                        && (issue_rd_fpr_i == f[0]) && (issue_rd_i == r[4:0]);
                    slot_clr[t][f][r] = slot_v[t][f][r] && !slot_wr[t][f][r]
                                        && clr_match(slot_id[t][f][r]);
                    if (slot_wr[t][f][r] && !slot_v[t][f][r]) cnt_inc[t] = 1'b1;
                    clr_cnt[t] = clr_cnt[t] + {6'd0, slot_clr[t][f][r]};
                end
            end
            cnt_calc[t] = $signed({2'b00, cnt_q[t]})
                        + $signed({{(CNT_BITS+1){1'b0}}, cnt_inc[t]})
                        - $signed({{(CNT_BITS-5){1'b0}}, clr_cnt[t]});
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                cnt_q[t] <= '0;
                for (int f = 0; f < 2; f++) begin
                    for (int r = 0; r < NREG; r++) begin
                        slot_v[t][f][r]  <= 1'b0;
                        slot_id[t][f][r] <= '0;
                    end
                end
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (flush_i[t]) begin
                    cnt_q[t] <= '0;
                    for (int f = 0; f < 2; f++) begin
                        for (int r = 0; r < NREG; r++) slot_v[t][f][r] <= 1'b0;
                    end
                end else begin
                    cnt_q[t] <= cnt_calc[t][CNT_BITS-1:0];
                    for (int f = 0; f < 2; f++) begin
                        for (int r = 0; r < NREG; r++) begin
                            if (slot_wr[t][f][r]) begin
                                slot_v[t][f][r]  <= 1'b1;
                                slot_id[t][f][r] <= issue_trans_id_i;
                            end else if (slot_clr[t][f][r]) begin
                                slot_v[t][f][r] <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Counter leaving [0, 2**CNT_BITS) means the scoreboard broke protocol.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (!flush_i[t]) assert (cnt_calc[t][CNT_BITS+1:CNT_BITS] == 2'b00);
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NR_RS; p++) begin
            valid_o[p] = 1'b0;
            idx_o[p]   = '0;
            if (int'(rs_thread_i[p]) < NUM_THREADS && slot_exists(rs_fpr_i[p], rs_i[p])) begin
                if (slot_v[rs_thread_i[p]][rs_fpr_i[p]][rs_i[p]]) begin
                    valid_o[p] = 1'b1;
                    idx_o[p]   = slot_id[rs_thread_i[p]][rs_fpr_i[p]][rs_i[p]];
                end
            end
        end
        for (int t = 0; t < NUM_THREADS; t++) begin
            pending_cnt_o[t] = cnt_q[t];
            empty_o[t]       = (cnt_q[t] == '0);
        end
    end

endmodule

// File: tb/tb_raw_tracker.sv
// Scoreboard bench for raw_tracker: one instance with the FPR table, one without, driven identically.
module tb_raw_tracker;
    localparam int NT = 2, TB = 3, NRS = 3, NCLR = 2, CB = 8;

    logic clk = 1'b0;
    logic rst;
    logic [NT-1:0] flush_i;
    logic issue_valid_i, issue_we_i, issue_rd_fpr_i;
    logic [0:0] issue_thread_i;
    logic [4:0] issue_rd_i;
    logic [TB-1:0] issue_trans_id_i;
    logic [NCLR-1:0] clr_valid_i;
    logic [NCLR-1:0][TB-1:0] clr_trans_id_i;
    logic [NRS-1:0][4:0] rs_i;
    logic [NRS-1:0] rs_fpr_i;
    logic [NRS-1:0][0:0] rs_thread_i;

    logic [NRS-1:0] valid0, valid1;
    logic [NRS-1:0][TB-1:0] idx0, idx1;
    logic [NT-1:0][CB-1:0] cnt0, cnt1;
    logic [NT-1:0] empty0, empty1;

    always #5 clk = ~clk;

    raw_tracker #(.FP_PRESENT(1)) dut_fp (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i), .issue_thread_i(issue_thread_i),
        .issue_rd_i(issue_rd_i), .issue_rd_fpr_i(issue_rd_fpr_i), .issue_trans_id_i(issue_trans_id_i),
        .clr_valid_i(clr_valid_i), .clr_trans_id_i(clr_trans_id_i),
        .rs_i(rs_i), .rs_fpr_i(rs_fpr_i), .rs_thread_i(rs_thread_i),
        .valid_o(valid0), .idx_o(idx0), .pending_cnt_o(cnt0), .empty_o(empty0));

    raw_tracker #(.FP_PRESENT(0)) dut_nofp (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i), .issue_thread_i(issue_thread_i),
        .issue_rd_i(issue_rd_i), .issue_rd_fpr_i(issue_rd_fpr_i), .issue_trans_id_i(issue_trans_id_i),
        .clr_valid_i(clr_valid_i), .clr_trans_id_i(clr_trans_id_i),
        .rs_i(rs_i), .rs_fpr_i(rs_fpr_i), .rs_thread_i(rs_thread_i),
        .valid_o(valid1), .idx_o(idx1), .pending_cnt_o(cnt1), .empty_o(empty1));

    typedef struct packed {
        logic [NRS-1:0]         v;
        logic [NRS-1:0][TB-1:0] idx;
        logic [NT-1:0][CB-1:0]  cnt;
        logic [NT-1:0]          empty;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    // Reference: youngest producer ID per (dut, thread, file, reg); -1 means none in flight.
    int prod [2][NT][2][32];
    bit known = 1'b0;
    int n_checks = 0;
    int n_pass = 0;

    function automatic exp_t predict(int d);
        exp_t e;
        int pr, c;
        e = '0;
        for (int p = 0; p < NRS; p++) begin
            pr = -1;
            if (!(rs_i[p] == 5'd0 && !rs_fpr_i[p]) && !(rs_fpr_i[p] && d == 1))
                pr = prod[d][rs_thread_i[p]][rs_fpr_i[p]][rs_i[p]];
            if (pr >= 0) begin
                e.v[p]   = 1'b1;
                e.idx[p] = TB'(pr);
            end
        end
        for (int t = 0; t < NT; t++) begin
            c = 0;
            for (int f = 0; f < 2; f++)
                for (int r = 0; r < 32; r++)
                    if (prod[d][t][f][r] >= 0) c++;
            e.cnt[t]   = CB'(c);
            e.empty[t] = (c == 0);
        end
        return e;
    endfunction

    function automatic void model_step();
        int cur, nx;
        for (int d = 0; d < 2; d++)
            for (int t = 0; t < NT; t++)
                for (int f = 0; f < 2; f++)
                    for (int r = 0; r < 32; r++) begin
                        cur = prod[d][t][f][r];
                        nx  = cur;
                        if (rst) nx = -1;
                        else begin
                            for (int k = 0; k < NCLR; k++)
                                if (clr_valid_i[k] && cur >= 0 && cur == int'(clr_trans_id_i[k])) nx = -1;
                            if (issue_valid_i && issue_we_i && int'(issue_thread_i) == t
                                && int'(issue_rd_fpr_i) == f && int'(issue_rd_i) == r
                                && !(r == 0 && f == 0) && !(f == 1 && d == 1))
                                nx = int'(issue_trans_id_i);
                            if (flush_i[t]) nx = -1;
                        end
                        prod[d][t][f][r] = nx;
                    end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    endtask

    task automatic cyc();
        if (known) begin
            q0.push_back(predict(0));
            q1.push_back(predict(1));
        end
        @(posedge clk);
        model_step();
        if (rst) known = 1'b1;
        #1;
    endtask

    task automatic idle();
        flush_i = '0; issue_valid_i = 0; issue_we_i = 0; issue_thread_i = '0;
        issue_rd_i = '0; issue_rd_fpr_i = 0; issue_trans_id_i = '0;
        clr_valid_i = '0; clr_trans_id_i = '0;
    endtask

    task automatic issue(input int t, input int f, input int r, input int id);
        issue_valid_i = 1; issue_we_i = 1; issue_thread_i = 1'(t);
        issue_rd_fpr_i = f[0]; issue_rd_i = 5'(r); issue_trans_id_i = TB'(id);
    endtask

    task automatic look(input int p, input int t, input int f, input int r);
        rs_thread_i[p] = 1'(t); rs_fpr_i[p] = f[0]; rs_i[p] = 5'(r);
    endtask

    // Monitor: every DUT output sample is checked against the oldest pending prediction.
    initial begin
        exp_t e0, e1;
        forever begin
            @(negedge clk);
            if (q0.size() > 0 && q1.size() > 0) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                chk("valid_fp",   64'(valid0), 64'(e0.v));
                chk("idx_fp",     64'(idx0),   64'(e0.idx));
                chk("cnt_fp",     64'(cnt0),   64'(e0.cnt));
                chk("empty_fp",   64'(empty0), 64'(e0.empty));
                chk("valid_nofp", 64'(valid1), 64'(e1.v));
                chk("idx_nofp",   64'(idx1),   64'(e1.idx));
                chk("cnt_nofp",   64'(cnt1),   64'(e1.cnt));
                chk("empty_nofp", 64'(empty1), 64'(e1.empty));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        idle();
        rs_i = '0; rs_fpr_i = '0; rs_thread_i = '0;
        // Reset for two cycles with an issue held active
        rst = 1;
        issue(0, 0, 5, 1);
        look(0, 0, 0, 5); look(1, 1, 0, 5); look(2, 0, 1, 5);
        cyc(); cyc();
        rst = 0; idle(); cyc();

        // Basic RAW
        issue(0, 0, 5, 3);
        look(0, 0, 0, 5); look(1, 1, 0, 5); look(2, 0, 0, 0);
        cyc(); idle(); cyc();

        // Overwrite, stale clear, duplicate clear IDs
        issue(0, 0, 5, 6); cyc(); idle();
        clr_valid_i = 2'b01; clr_trans_id_i[0] = 3; cyc(); idle();
        clr_valid_i = 2'b11; clr_trans_id_i[0] = 6; clr_trans_id_i[1] = 6; cyc(); idle(); cyc();

        // Same-cycle issue and clear of the same slot
        look(0, 0, 1, 3); look(1, 0, 1, 4); look(2, 1, 1, 3);
        issue(0, 1, 3, 2); cyc();
        issue(0, 1, 3, 2); clr_valid_i = 2'b10; clr_trans_id_i[1] = 2; cyc(); idle(); cyc();
        clr_valid_i = 2'b01; clr_trans_id_i[0] = 2; cyc(); idle(); cyc();

        // Flush of T1 with a T1 issue in the same cycle
        look(0, 1, 0, 1); look(1, 1, 0, 7); look(2, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin issue(1, 0, i + 1, i); cyc(); end
        issue(0, 0, 1, 4); cyc();
        idle(); flush_i = 2'b10; issue(1, 0, 7, 5); cyc(); idle(); cyc();
        // Flush T0 while T1 issues
        look(1, 1, 0, 9);
        flush_i = 2'b01; issue(1, 0, 9, 6); cyc(); idle(); cyc();

        // x0 and FPR handling across both instances
        look(0, 0, 0, 0); look(1, 0, 1, 1); look(2, 1, 1, 1);
        issue(0, 0, 0, 7); cyc();
        issue(0, 1, 1, 1); cyc();
        issue(1, 1, 1, 2); cyc(); idle(); cyc();

        // Randomized traffic with occasional flush and a mid-run reset
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 2) != 0)
                issue($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7));
            issue_we_i = ($urandom_range(0, 5) != 0);
            clr_valid_i = NCLR'($urandom_range(0, 3));
            clr_trans_id_i[0] = TB'($urandom_range(0, 7));
            clr_trans_id_i[1] = TB'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) flush_i = NT'($urandom_range(1, 3));
            for (int p = 0; p < NRS; p++)
                look(p, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7));
            rst = (n == 200);
            cyc();
        end
        rst = 0; idle(); cyc();

        @(negedge clk); #1;
        chk("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
